calc_entry_sequencer: RTL and testbench
=======================================

// Module: calc_entry_sequencer
// PURPOSE
// - Sequences decoded keypad codes (0-9 digits, 10 '+', 11 '-', 12 '*', 13 '=') into operand A, operator, operand B.
// - Issues one compute request to the arithmetic unit, waits for completion, and presents operand/result to display logic.
// - Sits between the PS/2 key decoder and the ALU/display path; owns all calculator entry state.
// PARAMETERS
// - W       16  operand/result width (unsigned)
// - DIGITS  4   max decimal digits per operand; 10^DIGITS-1 must be < 2^W
// PORTS
// - clk         in   1   system clock, all logic on rising edge
// - Reset       in   1   synchronous, active-low reset
// - key_code    in   4   decoded key; codes 14,15 are invalid
// - key_valid   in   1   one-cycle strobe qualifying key_code
// - alu_a       out  W   operand A to ALU
// - alu_b       out  W   operand B to ALU
// - alu_op      out  2   0 add, 1 sub, 2 mul (3 never driven)
// - alu_start   out  1   one-cycle request pulse
// - alu_done    in   1   one-cycle completion strobe; alu_result valid same cycle
// - alu_result  in   W   ALU result (already truncated to W)
// - disp_value  out  W   value to display
// - disp_sel    out  2   0 showing A, 1 showing B, 2 showing result
// - busy        out  1   high in ISSUE and WAIT
// - err         out  1   sticky: digit dropped due to DIGITS limit
// BEHAVIOUR
// - Reset (Reset=0 at edge): state ENTER_A; A, B, acc, digit count, alu_*, disp_value, err = 0; disp_sel=0; alu_start=0; busy=0.
// - All outputs registered; key_valid in cycle n takes effect at edge ending n, visible in cycle n+1.
// - States: ENTER_A, ENTER_B, ISSUE, WAIT, SHOW.
// - Digit d in ENTER_A/ENTER_B: if count<DIGITS, acc <= acc*10+d, count++; else digit ignored, err<=1.
// - Leading zeros count toward DIGITS.
// - ENTER_A: operator -> latch op, A<=acc (0 if no digits), clear acc/count, go ENTER_B, disp_sel=1; '=' ignored.
// - ENTER_B: operator with count==0 replaces op; with count>0 ignored. '=' with count==0 ignored; count>0 -> B<=acc, go ISSUE.
// - ISSUE: exactly one cycle, alu_start=1, alu_a/alu_b/alu_op driven, next WAIT. alu_a/b/op held stable until alu_done.
// - WAIT: all keys dropped (incl. same-cycle as alu_done). alu_done -> disp_value<=alu_result, disp_sel=2, go SHOW, busy falls.
// - alu_done outside WAIT ignored. No timeout: WAIT persists until alu_done or reset.
// - SHOW: digit d -> clear A/B/err, acc<=d, count=1, go ENTER_A, disp_sel=0. '=' ignored. Operator: see CONFIGURATION.
// - disp_value tracks acc in ENTER_A/ENTER_B, result in SHOW.
// - err cleared only by reset or leaving SHOW on a digit.
// - Invalid codes (14,15) ignored in every state, no state change.
// - Reset mid-WAIT: returns to ENTER_A; late alu_done after reset ignored.
// CONFIGURATION
// - CALC_CHAIN_EN defined: operator in SHOW -> A<=result, latch op, clear acc/count, go ENTER_B, disp_sel=1 (chained ops).
// - CALC_CHAIN_EN undefined: operator in SHOW ignored; only a digit leaves SHOW.
// TESTING
// - Keys 1,2,+,3,4,= ; alu_done with result 46 -> alu_start one cycle after '=', alu_a=12, alu_b=34, alu_op=0, disp_value=46, disp_sel=2.
// - Keys 9,9,9,9,9 (DIGITS=4) -> acc=9999, err=1; '*',2,'=' -> alu_a=9999, alu_b=2, alu_op=2.
// - Keys 5,+,-,7,= -> alu_op=1 (replacement), alu_b=7; '=' with empty B ignored, busy stays 0.
// - In WAIT, keys 3 and '+' plus unsolicited alu_done before start -> ignored; alu_a/b/op unchanged until real done.
// - SHOW result 20, key '*',3,'=' -> CHAIN_EN: alu_a=20, alu_b=3; without: stays SHOW, digit 3 starts new A=3.
// - Reset=0 during WAIT -> next cycle all outputs 0, state ENTER_A; subsequent alu_done ignored.

Source files
------------

// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: collects operand A, operator and operand B from keypad codes,
// issues one ALU request and shows the result. Define CALC_CHAIN_EN to let an operator in SHOW chain on the result.
module calc_entry_sequencer #(
  parameter int W      = 16,
  parameter int DIGITS = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic [3:0]   key_code,
  input  logic         key_valid,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] disp_value,
  output logic [1:0]   disp_sel,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {ENTER_A, ENTER_B, ISSUE, WAIT, SHOW} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]     alu_op_q, alu_op_d;
  logic           alu_start_q, alu_start_d;
  logic [W-1:0]   disp_value_q, disp_value_d;
  logic [1:0]     disp_sel_q, disp_sel_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;

  logic           is_digit, is_op, is_eq;
  logic [1:0]     key_op;
  logic [W-1:0]   key_val;

  always_comb begin
    is_digit = key_valid && (key_code <= 4'd9);
    is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
    is_eq    = key_valid && (key_code == 4'd13);
    key_op   = 2'(key_code - 4'd10);
    key_val  = W'(key_code);

    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = 1'b0;
    disp_value_d = disp_value_q;
    disp_sel_d   = disp_sel_q;
    busy_d       = busy_q;
    err_d        = err_q;

    case (state_q)
      ENTER_A, ENTER_B: begin
        if (is_digit) begin
          if (cnt_q < CW'(DIGITS)) begin
            acc_d = acc_q * W'(10) + key_val;
            cnt_d = cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end else if (state_q == ENTER_A) begin
          if (is_op) begin
            op_d       = key_op;
            a_d        = acc_q;
            acc_d      = '0;
            cnt_d      = '0;
            disp_sel_d = 2'd1;
            state_d    = ENTER_B;
          end
        end else begin
          // An operator is only a correction while B is still empty
          if (is_op && cnt_q == '0) begin
            op_d = key_op;
          end else if (is_eq && cnt_q != '0) begin
            b_d         = acc_q;
            alu_a_d     = a_q;
            alu_b_d     = acc_q;
            alu_op_d    = op_q;
            alu_start_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (alu_done) begin
          disp_value_d = alu_result;
          disp_sel_d   = 2'd2;
          busy_d       = 1'b0;
          state_d      = SHOW;
        end
      end
      SHOW: begin
        if (is_digit) begin
          a_d        = '0;
          b_d        = '0;
          err_d      = 1'b0;
          acc_d      = key_val;
          cnt_d      = CW'(1);
          disp_sel_d = 2'd0;
          state_d    = ENTER_A;
        end
`ifdef CALC_CHAIN_EN
        else if (is_op) begin
          a_d        = disp_value_q;
          op_d       = key_op;
          acc_d      = '0;
          cnt_d      = '0;
          disp_sel_d = 2'd1;
          state_d    = ENTER_B;
        end
`endif
      end
      default: state_d = ENTER_A;
    endcase

    if (state_d == ENTER_A || state_d == ENTER_B) begin
      disp_value_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q      <= ENTER_A;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      disp_value_q <= '0;
      disp_sel_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      disp_value_q <= disp_value_d;
      disp_sel_q   <= disp_sel_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign disp_value = disp_value_q;
  assign disp_sel   = disp_sel_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Bench for calc_entry_sequencer: expected ALU requests are queued when '=' is keyed
// and compared when alu_start appears; display/status outputs are checked directly.
module tb_calc_entry_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         Reset = 1'b0;
  logic [3:0]   key_code = '0;
  logic         key_valid = 1'b0;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_op;
  logic         alu_start;
  logic         alu_done = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic [W-1:0] disp_value;
  logic [1:0]   disp_sel;
  logic         busy, err;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W+1:0] exp_q[$];

  calc_entry_sequencer #(.W(W), .DIGITS(4)) dut (
    .clk(clk), .Reset(Reset), .key_code(key_code), .key_valid(key_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .disp_value(disp_value), .disp_sel(disp_sel), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every ALU request must match the oldest queued expectation
  always @(negedge clk) begin
    if (alu_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        logic [2*W+1:0] e;
        e = exp_q.pop_front();
        check("sb_alu_a", 32'(alu_a), 32'(e[2*W+1:W+2]));
        check("sb_alu_b", 32'(alu_b), 32'(e[W+1:2]));
        check("sb_alu_op", 32'(alu_op), 32'(e[1:0]));
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic done_pulse(input logic [W-1:0] r, input bit with_key);
    @(negedge clk);
    alu_done   = 1'b1;
    alu_result = r;
    if (with_key) begin
      key_code  = 4'd3;
      key_valid = 1'b1;
    end
    @(negedge clk);
    alu_done  = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic enter_eq(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [1:0] eop);
    exp_q.push_back({ea, eb, eop});
    press(4'd13);
    check("start_pulse", 32'(alu_start), 32'd1);
    check("busy_issue", 32'(busy), 32'd1);
    @(negedge clk);
    check("start_fall", 32'(alu_start), 32'd0);
    check("busy_wait", 32'(busy), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check({tag, "_alu_start"}, 32'(alu_start), 32'd0);
    check({tag, "_disp_value"}, 32'(disp_value), 32'd0);
    check({tag, "_disp_sel"}, 32'(disp_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    Reset = 1'b1;

    // 12 + 34 = 46
    press(4'd13);
    check("eq_in_a_ignored", 32'(busy), 32'd0);
    press(4'd1);
    check("a_digit1", 32'(disp_value), 32'd1);
    press(4'd14);
    press(4'd15);
    check("invalid_ignored", 32'(disp_value), 32'd1);
    check("invalid_sel", 32'(disp_sel), 32'd0);
    press(4'd2);
    check("a_12", 32'(disp_value), 32'd12);
    press(4'd10);
    check("op_sel_b", 32'(disp_sel), 32'd1);
    check("op_clears_acc", 32'(disp_value), 32'd0);
    press(4'd3);
    press(4'd4);
    check("b_34", 32'(disp_value), 32'd34);
    enter_eq(16'd12, 16'd34, 2'd0);
    done_pulse(16'd46, 1'b0);
    check("res_46", 32'(disp_value), 32'd46);
    check("res_sel", 32'(disp_sel), 32'd2);
    check("res_busy", 32'(busy), 32'd0);

    // Digit-limit overflow, then 9999 * 2
    for (int i = 0; i < 4; i++) press(4'd9);
    check("acc_9999", 32'(disp_value), 32'd9999);
    check("err_before_ovf", 32'(err), 32'd0);
    press(4'd9);
    check("acc_held", 32'(disp_value), 32'd9999);
    check("err_ovf", 32'(err), 32'd1);
    press(4'd12);
    press(4'd2);
    enter_eq(16'd9999, 16'd2, 2'd2);
    done_pulse(16'd19998, 1'b0);
    check("res_19998", 32'(disp_value), 32'd19998);
    check("err_sticky_show", 32'(err), 32'd1);

    // Operator replacement, empty-B '=', stray done, keys during WAIT
    press(4'd5);
    check("err_cleared", 32'(err), 32'd0);
    check("show_digit_sel", 32'(disp_sel), 32'd0);
    press(4'd10);
    press(4'd11);
    press(4'd13);
    check("empty_b_eq_busy", 32'(busy), 32'd0);
    check("empty_b_eq_sel", 32'(disp_sel), 32'd1);
    press(4'd7);
    done_pulse(16'd999, 1'b0);
    check("stray_done_val", 32'(disp_value), 32'd7);
    check("stray_done_sel", 32'(disp_sel), 32'd1);
    enter_eq(16'd5, 16'd7, 2'd1);
    press(4'd3);
    press(4'd10);
    check("wait_alu_a", 32'(alu_a), 32'd5);
    check("wait_alu_b", 32'(alu_b), 32'd7);
    check("wait_alu_op", 32'(alu_op), 32'd1);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_sel", 32'(disp_sel), 32'd1);
    done_pulse(16'hFFFE, 1'b1);
    check("res_sub", 32'(disp_value), 32'hFFFE);
    check("done_key_dropped", 32'(disp_sel), 32'd2);

    // Result 20, then '*', 3, '='
    press(4'd4);
    press(4'd12);
    press(4'd5);
    enter_eq(16'd4, 16'd5, 2'd2);
    done_pulse(16'd20, 1'b0);
    check("res_20", 32'(disp_value), 32'd20);
    press(4'd12);
`ifdef CALC_CHAIN_EN
    check("chain_sel", 32'(disp_sel), 32'd1);
    press(4'd3);
    enter_eq(16'd20, 16'd3, 2'd2);
    done_pulse(16'd60, 1'b0);
    check("chain_res", 32'(disp_value), 32'd60);
`else
    check("nochain_sel", 32'(disp_sel), 32'd2);
    check("nochain_val", 32'(disp_value), 32'd20);
    press(4'd3);
    check("nochain_newa_sel", 32'(disp_sel), 32'd0);
    check("nochain_newa_val", 32'(disp_value), 32'd3);
    press(4'd13);
    check("nochain_eq_ignored", 32'(busy), 32'd0);
    press(4'd10);
    press(4'd1);
    enter_eq(16'd3, 16'd1, 2'd0);
    done_pulse(16'd4, 1'b0);
    check("nochain_res", 32'(disp_value), 32'd4);
`endif

    // Reset while waiting; a late done must be ignored
    press(4'd8);
    press(4'd11);
    press(4'd6);
    enter_eq(16'd8, 16'd6, 2'd1);
    Reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_wait");
    Reset = 1'b1;
    done_pulse(16'd77, 1'b0);
    check("late_done_val", 32'(disp_value), 32'd0);
    check("late_done_sel", 32'(disp_sel), 32'd0);
    check("late_done_busy", 32'(busy), 32'd0);
    press(4'd2);
    press(4'd10);
    press(4'd3);
    enter_eq(16'd2, 16'd3, 2'd0);
    done_pulse(16'd5, 1'b0);
    check("post_rst_res", 32'(disp_value), 32'd5);

    @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
